// File: rtl/npu_bus_arbiter.sv
// npu_bus_arbiter: host-priority, round-robin PE bus arbiter with burst cap.
// Optional NPU_ARB_TURNAROUND_EN inserts a 1-cycle idle TURN on every handoff.
module npu_bus_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int ID_W      = 3,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_req,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] gnt,
  output logic               host_gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_PE   = 2'd1,
    OWN_HOST = 2'd2
`ifdef NPU_ARB_TURNAROUND_EN
    ,
    TURN     = 2'd3
`endif
  } state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               host_gnt_d;
  logic [ID_W-1:0]    gnt_id_d;
  logic [CW-1:0]      beat_cnt, beat_cnt_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;

  logic               pick_ok;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    cand;
  logic               own_req;
  logic               beat;
  logic               at_cap;
  logic               rel;
  logic               arb;

  // Round-robin pick: first requesting PE at or after rr_ptr, with wrap.
  always_comb begin
    pick_ok = 1'b0;
    pick_id = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr + ID_W'(i);
      if (!pick_ok && req[cand]) begin
        pick_ok = 1'b1;
        pick_id = cand;
      end
    end
  end

  // Owner status: beat detection and release decision for this cycle.
  always_comb begin
    own_req = 1'b0;
    rel     = 1'b0;
    at_cap  = (beat_cnt == CW'(MAX_BURST - 1));
    unique case (state)
      OWN_PE: begin
        own_req = req[gnt_id];
        rel     = !own_req || last[gnt_id] || at_cap;
      end
      OWN_HOST: begin
        own_req = host_req;
        rel     = !own_req || at_cap;
      end
      default: begin
        own_req = 1'b0;
        rel     = 1'b0;
      end
    endcase
    beat = own_req;
  end

  // Next-state and next-grant logic; grants are decided here and registered.
  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    host_gnt_d = host_gnt;
    gnt_id_d   = gnt_id;
    beat_cnt_d = beat_cnt;
    rr_ptr_d   = rr_ptr;
    arb        = (state == IDLE);
`ifdef NPU_ARB_TURNAROUND_EN
    arb = arb || (state == TURN);
`else
    arb = arb || rel;
`endif
    if (beat) begin
      beat_cnt_d = beat_cnt + CW'(1);
    end
`ifdef NPU_ARB_TURNAROUND_EN
    if (rel) begin
      state_d    = TURN;
      gnt_d      = '0;
      host_gnt_d = 1'b0;
      gnt_id_d   = '0;
      beat_cnt_d = '0;
    end
`endif
    if (arb) begin
      state_d    = IDLE;
      gnt_d      = '0;
      host_gnt_d = 1'b0;
      gnt_id_d   = '0;
      beat_cnt_d = '0;
      if (host_req) begin
        state_d    = OWN_HOST;
        host_gnt_d = 1'b1;
      end else if (pick_ok) begin
        state_d  = OWN_PE;
        gnt_d    = NUM_REQ'(1) << pick_id;
        gnt_id_d = pick_id;
        rr_ptr_d = pick_id + ID_W'(1);
      end
    end
  end

  // Registered grants and arbitration state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      host_gnt <= 1'b0;
      gnt_id   <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      host_gnt <= host_gnt_d;
      gnt_id   <= gnt_id_d;
      beat_cnt <= beat_cnt_d;
      rr_ptr   <= rr_ptr_d;
    end
  end

  assign gnt_valid = (|gnt) | host_gnt;

`ifndef SYNTHESIS
  // Only one driver may ever be enabled on the bus.
  a_one_driver : assert property (
    @(posedge clk) disable iff (!rst) $onehot0({gnt, host_gnt})
  );
`endif

endmodule
